v_chunk_fifo: RTL and testbench

//  Vector-chunk buffer between mlops stages. Producer side accepts WorkingRegs-wide chunks
//  (driven by an upstream op's req_chunk_out/write_out_data). Consumer side serves chunks
//  to a downstream op's req_chunk_in, and raises data_ready once a whole vector is stored.

---
 rtl/mlops_pkg.sv | 16 +
 rtl/chunk_regfile.sv | 26 ++
 rtl/v_chunk_fifo.sv | 127 ++++++++++++
 tb/tb_v_chunk_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mlops_pkg.sv
// Shared element width and index/count width helpers for the mlops vector datapath.
package mlops_pkg;

   localparam int NBits = 8;

   // Width of an index/pointer over n slots; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/chunk_regfile.sv
// 1W/1R chunk storage: synchronous write, asynchronous read, data not reset.
module chunk_regfile
   import mlops_pkg::*;
#(
   parameter int Depth = 8,
   parameter int Width = 32
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic [idx_w(Depth)-1:0] waddr_i,
   input  logic [Width-1:0]        wdata_i,
   input  logic [idx_w(Depth)-1:0] raddr_i,
   output logic [Width-1:0]        rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/v_chunk_fifo.sv
// First-word-fall-through chunk FIFO that tracks vector boundaries between mlops stages.
module v_chunk_fifo
   import mlops_pkg::*;
#(
   parameter int VecLength   = 16,
   parameter int WorkingRegs = 4,
   parameter int DepthVecs   = 2
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    wr_en,
   input  logic signed [WorkingRegs-1:0][NBits-1:0] wr_data,
   output logic                                    wr_full,
   input  logic                                    rd_en,
   output logic signed [WorkingRegs-1:0][NBits-1:0] rd_data,
   output logic                                    rd_vec_last,
   output logic                                    data_ready,
   output logic                                    overflow_err,
   output logic                                    underflow_err
);

   localparam int ChunksPerVec = VecLength / WorkingRegs;
   localparam int DepthChunks  = DepthVecs * ChunksPerVec;
   localparam int CW = WorkingRegs * NBits;
   localparam int PW = idx_w(DepthChunks);
   localparam int KW = cnt_w(DepthChunks);
   localparam int IW = idx_w(ChunksPerVec);
   localparam int VW = cnt_w(DepthVecs + 1);

   if ((VecLength % WorkingRegs) != 0 || DepthVecs < 1) begin : g_param_err
      $error("v_chunk_fifo: VecLength must be a multiple of WorkingRegs and DepthVecs >= 1");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [KW-1:0] count_q, count_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [VW-1:0] vec_cnt_q, vec_cnt_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          push_ok, pop_ok, wr_wrap, rd_wrap, vec_done_wr, vec_done_rd;
   logic [CW-1:0] wr_flat, rd_flat;

   assign wr_full = (count_q == KW'(DepthChunks));
   assign wr_flat = wr_data;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      vec_cnt_d = vec_cnt_q;

      // An empty FIFO never bypasses a same-cycle push to the read side.
      pop_ok      = rd_en && (count_q != '0);
      push_ok     = wr_en && (!wr_full || pop_ok);
      wr_wrap     = (wr_idx_q == IW'(ChunksPerVec - 1));
      rd_wrap     = (rd_idx_q == IW'(ChunksPerVec - 1));
      vec_done_wr = push_ok && wr_wrap;
      vec_done_rd = pop_ok && rd_wrap;

      ovf_d = ovf_q | (wr_en && !push_ok);
      unf_d = unf_q | (rd_en && (count_q == '0));

      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PW'(DepthChunks - 1)) ? '0 : wr_ptr_q + PW'(1);
         wr_idx_d = wr_wrap ? '0 : wr_idx_q + IW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PW'(DepthChunks - 1)) ? '0 : rd_ptr_q + PW'(1);
         rd_idx_d = rd_wrap ? '0 : rd_idx_q + IW'(1);
      end

      if (push_ok && !pop_ok) begin
         count_d = count_q + KW'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - KW'(1);
      end

      if (vec_done_wr && !vec_done_rd) begin
         vec_cnt_d = vec_cnt_q + VW'(1);
      end else if (!vec_done_wr && vec_done_rd) begin
         vec_cnt_d = vec_cnt_q - VW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         vec_cnt_q <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         vec_cnt_q <= vec_cnt_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   chunk_regfile #(
      .Depth (DepthChunks),
      .Width (CW)
   ) u_regfile (
      .clk_i   (clk_in),
      .we_i    (push_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_flat),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_flat)
   );

   // Storage is not reset, so the head is masked to zero while empty.
   assign rd_data       = (count_q != '0) ? rd_flat : '0;
   assign rd_vec_last   = (count_q != '0) && rd_wrap;
   assign data_ready    = (vec_cnt_q != '0);
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule

// File: tb/tb_v_chunk_fifo.sv
// Scoreboard bench for v_chunk_fifo: default geometry plus a one-chunk-per-vector instance.
module tb_v_chunk_fifo;
   import mlops_pkg::*;

   localparam int WR    = 4;
   localparam int CPV   = 4;
   localparam int DEPTH = 8;
   localparam int WR1   = 16;

   typedef logic [WR-1:0][NBits-1:0]  ch_t;
   typedef logic [WR1-1:0][NBits-1:0] ch1_t;
   typedef struct packed { ch_t d; logic last; } exp_t;

   logic clk, rst_n;
   logic wr_en, rd_en, wr_full, rd_vec_last, data_ready, ovf, unf;
   ch_t  wr_data, rd_data;
   logic wr_en1, rd_en1, wr_full1, rd_vec_last1, data_ready1, ovf1, unf1;
   ch1_t wr_data1, rd_data1;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   ch1_t exp1_q[$];
   ch_t  mq[$];
   logic ml[$];
   int   m_widx, m_vc;
   logic m_ovf, m_unf;

   v_chunk_fifo #(.VecLength(16), .WorkingRegs(WR), .DepthVecs(2)) u_dut (
      .clk_in(clk), .rst_in(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .rd_en(rd_en), .rd_data(rd_data), .rd_vec_last(rd_vec_last), .data_ready(data_ready),
      .overflow_err(ovf), .underflow_err(unf));

   v_chunk_fifo #(.VecLength(16), .WorkingRegs(WR1), .DepthVecs(2)) u_dut1 (
      .clk_in(clk), .rst_in(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .wr_full(wr_full1),
      .rd_en(rd_en1), .rd_data(rd_data1), .rd_vec_last(rd_vec_last1), .data_ready(data_ready1),
      .overflow_err(ovf1), .underflow_err(unf1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ch_t mk(input int base);
      ch_t c;
      for (int j = 0; j < WR; j++) c[j] = NBits'(base + j);
      return c;
   endfunction

   function automatic ch1_t mk1(input int base);
      ch1_t c;
      for (int j = 0; j < WR1; j++) c[j] = NBits'(base + 3 * j);
      return c;
   endfunction

   task automatic model_reset();
      mq.delete();
      ml.delete();
      m_widx = 0;
      m_vc   = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic check_flags(input string tag);
      chk({tag, ".wr_full"}, 128'(wr_full), 128'(mq.size() == DEPTH));
      chk({tag, ".data_ready"}, 128'(data_ready), 128'(m_vc > 0));
      chk({tag, ".rd_vec_last"}, 128'(rd_vec_last), 128'((mq.size() > 0) ? ml[0] : 1'b0));
      chk({tag, ".overflow_err"}, 128'(ovf), 128'(m_ovf));
      chk({tag, ".underflow_err"}, 128'(unf), 128'(m_unf));
   endtask

   // One clock of stimulus on the main instance; called at posedge+1.
   task automatic cyc(input string tag, input logic w, input ch_t d, input logic r);
      logic pop, push, lst;
      exp_t e;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      pop  = r && (mq.size() > 0);
      push = w && ((mq.size() < DEPTH) || pop);
      if (r) begin
         e = pop ? {mq[0], ml[0]} : '0;
         exp_q.push_back(e);
      end
      if (w && !push) m_ovf = 1'b1;
      if (r && mq.size() == 0) m_unf = 1'b1;
      @(posedge clk);
      if (pop) begin
         if (ml[0]) m_vc--;
         void'(mq.pop_front());
         void'(ml.pop_front());
      end
      if (push) begin
         lst = (m_widx == CPV - 1);
         mq.push_back(d);
         ml.push_back(lst);
         if (lst) m_vc++;
         m_widx = lst ? 0 : m_widx + 1;
      end
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_flags(tag);
   endtask

   task automatic cyc1(input logic w, input ch1_t d, input logic r, input ch1_t e);
      wr_en1   = w;
      wr_data1 = d;
      rd_en1   = r;
      if (r) exp1_q.push_back(e);
      @(posedge clk);
      #1;
      wr_en1 = 1'b0;
      rd_en1 = 1'b0;
   endtask

   // Monitors: compare the presented head on every cycle the consumer pops.
   always @(negedge clk) begin
      exp_t e;
      if (rd_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
         end else begin
            e = exp_q.pop_front();
            chk("pop.rd_data", 128'(rd_data), 128'(e.d));
            chk("pop.rd_vec_last", 128'(rd_vec_last), 128'(e.last));
         end
      end
   end

   always @(negedge clk) begin
      ch1_t e;
      if (rd_en1) begin
         if (exp1_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop1_unexpected actual=%0h required=none", rd_data1);
         end else begin
            e = exp1_q.pop_front();
            chk("pop1.rd_data", 128'(rd_data1), 128'(e));
         end
      end
   end

   initial begin
      ch_t sgn;
      rst_n = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      wr_en1 = 1'b0; rd_en1 = 1'b0; wr_data1 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wr_full", 128'(wr_full), 128'(0));
      chk("rst.data_ready", 128'(data_ready), 128'(0));
      chk("rst.rd_vec_last", 128'(rd_vec_last), 128'(0));
      chk("rst.rd_data", 128'(rd_data), 128'(0));
      chk("rst.errs", 128'({ovf, unf}), 128'(0));
      rst_n = 1'b1;

      // Reset mid-vector discards the partial vector asynchronously.
      for (int k = 0; k < 3; k++) cyc("t1.push", 1'b1, mk(4 * k), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t1.async.rd_data", 128'(rd_data), 128'(0));
      chk("t1.async.flags", 128'({wr_full, data_ready, rd_vec_last, ovf, unf}), 128'(0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("t1.underflow", 1'b0, '0, 1'b1);
      chk("t1.rd_data_after", 128'(rd_data), 128'(0));

      for (int k = 0; k < CPV; k++) cyc("t2.push", 1'b1, mk(4 * k), 1'b0);
      for (int k = 0; k < CPV; k++) cyc("t2.pop", 1'b0, '0, 1'b1);

      for (int k = 0; k < DEPTH; k++) cyc("t3.fill", 1'b1, mk(100 + 4 * k), 1'b0);
      cyc("t3.drop", 1'b1, mk(200), 1'b0);
      cyc("t3.pushpop_full", 1'b1, mk(204), 1'b1);
      for (int k = 0; k < DEPTH; k++) cyc("t3.drain", 1'b0, '0, 1'b1);

      cyc("t4.first", 1'b1, mk(0), 1'b0);
      for (int k = 1; k < 40; k++) cyc("t4.stream", 1'b1, mk(4 * k), 1'b1);
      cyc("t4.last", 1'b0, '0, 1'b1);

      sgn[0] = 8'h80; sgn[1] = 8'hFF; sgn[2] = 8'h00; sgn[3] = 8'h7F;
      cyc("t5.push_signed", 1'b1, sgn, 1'b0);
      cyc("t5.pop_signed", 1'b0, '0, 1'b1);

      // One chunk per vector: every push completes a vector.
      cyc1(1'b1, mk1(1), 1'b0, '0);
      chk("t5w.data_ready_1", 128'(data_ready1), 128'(1));
      chk("t5w.rd_vec_last_1", 128'(rd_vec_last1), 128'(1));
      cyc1(1'b1, mk1(50), 1'b0, '0);
      chk("t5w.wr_full", 128'(wr_full1), 128'(1));
      cyc1(1'b0, '0, 1'b1, mk1(1));
      chk("t5w.data_ready_2", 128'(data_ready1), 128'(1));
      chk("t5w.rd_vec_last_2", 128'(rd_vec_last1), 128'(1));
      cyc1(1'b0, '0, 1'b1, mk1(50));
      chk("t5w.data_ready_empty", 128'(data_ready1), 128'(0));
      chk("t5w.rd_vec_last_empty", 128'(rd_vec_last1), 128'(0));
      chk("t5w.errs", 128'({ovf1, unf1}), 128'(0));

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
